nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer: feeds one nibble per clock, LSB first,
// to an external 4-bit adder slice and returns {cout,sum} over valid/ready.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sumShift_q, sumShift_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] sumShifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sumShift_q <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sumShift_q <= sumShift_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
        end
    end

    // The newest slice sum enters at the top so the LSB nibble ends up at the bottom.
    always_comb begin
        sumShifted               = sumShift_q >> 4;
        sumShifted[WIDTH-1 -: 4] = add_s;

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sumShift_d = sumShift_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        cout_d     = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d        = a_q >> 4;
                b_d        = b_q >> 4;
                sumShift_d = sumShifted;
                carry_d    = add_co;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    sum_d   = sumShifted;
                    cout_d  = add_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign add_a     = (state_q == RUN) ? a_q[3:0] : 4'd0;
    assign add_b     = (state_q == RUN) ? b_q[3:0] : 4'd0;
    assign add_cin   = (state_q == RUN) ? carry_q  : 1'b0;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16) with a
// behavioural 4-bit adder slice wired to the add_* ports.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_co;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int nChecks = 0;
    int nFails  = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    // External 4-bit ripple-carry slice
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b0;
        #2;
        nChecks++; if (in_ready !== 1'b1)  begin nFails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nChecks++; if (busy !== 1'b0)      begin nFails++; $display("FAIL reset_busy got %b want 0", busy); end
        nChecks++; if (sum !== 16'h0000 || cout !== 1'b0) begin nFails++; $display("FAIL reset_result got %b/%h want 0/0000", cout, sum); end
        nChecks++; if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin nFails++; $display("FAIL reset_add got %h %h %b want 0 0 0", add_a, add_b, add_cin); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3:0] expA [4];
        expA = '{4'h4, 4'h3, 4'h2, 4'h1};
        op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            nChecks++; if (add_a !== expA[k]) begin nFails++; $display("FAIL basic_add_a[%0d] got %h want %h", k, add_a, expA[k]); end
            nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL basic_early_valid[%0d] got %b want 0", k, out_valid); end
        end
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL basic_latency got out_valid %b want 1", out_valid); end
        nChecks++; if (sum !== 16'h5555 || cout !== 1'b0) begin nFails++; $display("FAIL basic_result got %b/%h want 0/5555", cout, sum); end
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nFails++; $display("FAIL basic_return_idle got rdy %b vld %b want 1 0", in_ready, out_valid); end
        nChecks++; if (sum !== 16'h5555) begin nFails++; $display("FAIL basic_sum_hold got %h want 5555", sum); end
    endtask

    task automatic test_carry_chain();
        op_a = 16'hFFFF; op_b = 16'h0000; op_cin = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            nChecks++; if (add_cin !== 1'b1) begin nFails++; $display("FAIL carry_add_cin[%0d] got %b want 1", k, add_cin); end
        end
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin nFails++; $display("FAIL carry_result got vld %b %b/%h want 1 1/0000", out_valid, cout, sum); end
        @(negedge clk);
    endtask

    task automatic test_max_then_small();
        op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++; if (out_valid !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin nFails++; $display("FAIL max_result got vld %b %b/%h want 1 1/ffff", out_valid, cout, sum); end
        @(negedge clk);
        op_a = 16'h0001; op_b = 16'h0003; op_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++; if (out_valid !== 1'b1 || sum !== 16'h0004 || cout !== 1'b0) begin nFails++; $display("FAIL small_result got vld %b %b/%h want 1 0/0004", out_valid, cout, sum); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b1;
            nChecks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nFails++; $display("FAIL bp_hold[%0d] got vld %b rdy %b want 1 0", k, out_valid, in_ready); end
            nChecks++; if (sum !== 16'h3333 || cout !== 1'b0) begin nFails++; $display("FAIL bp_stable[%0d] got %b/%h want 0/3333", k, cout, sum); end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nFails++; $display("FAIL bp_release got rdy %b vld %b want 1 0", in_ready, out_valid); end
        @(negedge clk);
        nChecks++; if (busy !== 1'b0 || sum !== 16'h3333) begin nFails++; $display("FAIL bp_no_capture got busy %b sum %h want 0 3333", busy, sum); end
    endtask

    task automatic test_reset_mid_run();
        op_a = 16'h5678; op_b = 16'h1111; op_cin = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin nFails++; $display("FAIL midrst_flags got busy %b rdy %b vld %b want 0 1 0", busy, in_ready, out_valid); end
        nChecks++; if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin nFails++; $display("FAIL midrst_add got %h %h %b want 0 0 0", add_a, add_b, add_cin); end
        nChecks++; if (sum !== 16'h0000 || cout !== 1'b0) begin nFails++; $display("FAIL midrst_result got %b/%h want 0/0000", cout, sum); end
        @(negedge clk);
        rst_n = 1'b1;
        op_a = 16'h0F0F; op_b = 16'h00F1; op_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++; if (out_valid !== 1'b1 || sum !== 16'h1000 || cout !== 1'b0) begin nFails++; $display("FAIL midrst_after got vld %b %b/%h want 1 0/1000", out_valid, cout, sum); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] sa [3];
        logic [15:0] sb [3];
        logic        sc [3];
        logic [16:0] sr [3];
        sa = '{16'h1234, 16'h8000, 16'hABCD};
        sb = '{16'h4321, 16'h8000, 16'h1111};
        sc = '{1'b0, 1'b1, 1'b0};
        sr = '{17'h05555, 17'h10001, 17'h0BCDE};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = sa[i]; op_b = sb[i]; op_cin = sc[i]; in_valid = 1'b1;
            nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL stream_accept[%0d] got rdy %b want 1", i, in_ready); end
            repeat (5) @(negedge clk);
            nChecks++; if (out_valid !== 1'b1 || {cout, sum} !== sr[i]) begin nFails++; $display("FAIL stream_result[%0d] got vld %b %b/%h want 1 %h", i, out_valid, cout, sum, sr[i]); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_max_then_small();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
